// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// func-field opcodes, FSM state encoding and operation-kind encoding.
package muldiv_pkg;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        KIND_MULT  = 2'd0,
        KIND_DIV   = 2'd1,
        KIND_MULTU = 2'd2,
        KIND_DIVU  = 2'd3
    } kind_t;

    function automatic logic kind_is_div(input kind_t k);
        return (k == KIND_DIV) || (k == KIND_DIVU);
    endfunction

    function automatic logic kind_is_signed(input kind_t k);
        return (k == KIND_MULT) || (k == KIND_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// MULT: shift-add, {acc, shreg} shifts right, multiplier bits leave shreg[0].
// DIV:  restoring shift-subtract, remainder in acc, dividend shifts out of
//       shreg[WIDTH-1] while quotient bits shift in at shreg[0].
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] shreg,
    input  logic [WIDTH-1:0] operand,
    input  kind_t            kind,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] shreg_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] partial;
    logic [WIDTH:0] trial;

    // Single shift-add or shift-subtract step selected by the op kind.
    always_comb begin
        sum       = shreg[0] ? ({1'b0, acc} + {1'b0, operand}) : {1'b0, acc};
        partial   = {acc, shreg[WIDTH-1]};
        // Partial remainder is < 2*divisor, so WIDTH+1 bits hold it and the
        // borrow lands in the top bit exactly when the trial goes negative.
        trial     = partial - {1'b0, operand};
        acc_nxt   = sum[WIDTH:1];
        shreg_nxt = {sum[0], shreg[WIDTH-1:1]};
        if (kind_is_div(kind)) begin
            if (!trial[WIDTH]) begin
                acc_nxt   = trial[WIDTH-1:0];
                shreg_nxt = {shreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt   = partial[WIDTH-1:0];
                shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide unit owning the HI/LO registers.
// Optional build macro MULDIV_UNSIGNED_EN adds MULTU/DIVU.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting for start; hi/lo hold the last result
//  ST_RUN  | one datapath step per edge, WIDTH edges total
//  ST_FIX  | sign correction, hi/lo write, done pulse on exit
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state, state_nxt;
    kind_t              op_kind, kind;
    logic               op_valid;
    logic               accept;
    logic               zero_div;
    logic               sgn_rs, sgn_rt;
    logic [WIDTH-1:0]   mag_rs, mag_rt;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   acc, shreg, operand;
    logic [WIDTH-1:0]   acc_nxt, shreg_nxt;
    logic               s_rs, s_rt, dz;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Decode the func field into an op kind; unknown funcs are not accepted.
    always_comb begin
        op_valid = 1'b0;
        op_kind  = KIND_MULT;
        case (op)
            OP_MULT: begin op_valid = 1'b1; op_kind = KIND_MULT; end
            OP_DIV:  begin op_valid = 1'b1; op_kind = KIND_DIV;  end
`ifdef MULDIV_UNSIGNED_EN
            OP_MULTU: begin op_valid = 1'b1; op_kind = KIND_MULTU; end
            OP_DIVU:  begin op_valid = 1'b1; op_kind = KIND_DIVU;  end
`endif
            default: ;
        endcase
    end

    // Request qualification and operand magnitudes for the incoming op.
    always_comb begin
        accept   = (state == ST_IDLE) && start && op_valid;
        zero_div = kind_is_div(op_kind) && (rt_val == '0);
        sgn_rs   = kind_is_signed(op_kind) && rs_val[WIDTH-1];
        sgn_rt   = kind_is_signed(op_kind) && rt_val[WIDTH-1];
        mag_rs   = sgn_rs ? -rs_val : rs_val;
        mag_rt   = sgn_rt ? -rt_val : rt_val;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc       (acc),
        .shreg     (shreg),
        .operand   (operand),
        .kind      (kind),
        .acc_nxt   (acc_nxt),
        .shreg_nxt (shreg_nxt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a divide by zero goes straight to FIX.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = zero_div ? ST_FIX : ST_RUN;
            ST_RUN:  if (count == '0) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Signed results from the magnitude datapath; unsigned kinds latched clear signs.
    always_comb begin
        prod_fix = (s_rs ^ s_rt) ? -{acc, shreg} : {acc, shreg};
        quo_fix  = (s_rs ^ s_rt) ? -shreg : shreg;
        rem_fix  = s_rs ? -acc : acc;
    end

    // Operand latch, iteration, and HI/LO/flag writes.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            kind        <= KIND_MULT;
            s_rs        <= 1'b0;
            s_rt        <= 1'b0;
            dz          <= 1'b0;
            count       <= '0;
            acc         <= '0;
            shreg       <= '0;
            operand     <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    kind        <= op_kind;
                    s_rs        <= sgn_rs;
                    s_rt        <= sgn_rt;
                    dz          <= zero_div;
                    count       <= CNT_W'(WIDTH - 1);
                    div_by_zero <= 1'b0;
                    // Divide by zero parks the raw dividend in acc for hi.
                    acc         <= zero_div ? rs_val : '0;
                    shreg       <= kind_is_div(op_kind) ? mag_rs : mag_rt;
                    operand     <= kind_is_div(op_kind) ? mag_rt : mag_rs;
                end
                ST_RUN: begin
                    acc   <= acc_nxt;
                    shreg <= shreg_nxt;
                    count <= count - CNT_W'(1);
                end
                ST_FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    if (dz) begin
                        hi <= acc;
                        lo <= '1;
                    end else if (kind_is_div(kind)) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam int         LIMIT   = 200;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  op = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_bad = 0;

    // Last result the bench expects the unit to be holding.
    logic [31:0] hold_hi = '0;
    logic [31:0] hold_lo = '0;
    logic        hold_dz = 1'b0;

    muldiv_sequencer dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic v, output logic [31:0] eh, output logic [31:0] el,
                                  output logic ez);
        longint sa, sb, p, q, r;
        logic [63:0] up;
        v = 1'b0; eh = '0; el = '0; ez = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            F_MULT: begin v = 1'b1; p = sa * sb; {eh, el} = p; end
            F_DIV: begin
                v = 1'b1;
                if (b == 0) begin ez = 1'b1; el = 32'hFFFF_FFFF; eh = a; end
                else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
            end
`ifdef MULDIV_UNSIGNED_EN
            F_MULTU: begin v = 1'b1; up = {32'b0, a} * {32'b0, b}; {eh, el} = up; end
            F_DIVU: begin
                v = 1'b1;
                if (b == 0) begin ez = 1'b1; el = 32'hFFFF_FFFF; eh = a; end
                else begin el = a / b; eh = a % b; end
            end
`endif
            default: begin up = '0; end
        endcase
    endfunction

    // Issue one request, scramble the input bus after acceptance, wait for done.
    task automatic issue_and_wait(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output int lat, output int bsy, output logic ovl,
                                  output logic tmo, output logic dz_acc);
        @(negedge clk);
        start = 1'b1; op = f; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
        lat = 0; bsy = busy ? 1 : 0; ovl = busy && done; tmo = 1'b0;
        dz_acc = div_by_zero;
        while (!done && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bsy++;
            if (busy && done) ovl = 1'b1;
        end
        if (!done) tmo = 1'b1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        #2;
        n_vec++;
        if ({busy, done, div_by_zero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b dbz=%b hi=%h lo=%h, want all zero",
                     busy, done, div_by_zero, hi, lo);
        end
        @(negedge clk); @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult_basic();
        int lat, bsy; logic ovl, tmo, dza;
        issue_and_wait(F_MULT, 32'd7, 32'hFFFF_FFFD, lat, bsy, ovl, tmo, dza);
        n_vec++;
        if (tmo || lat != 33) begin
            n_bad++; $display("FAIL mult_latency: got %0d edges (timeout=%b), want 33", lat, tmo);
        end
        n_vec++;
        if (bsy != 33 || ovl) begin
            n_bad++; $display("FAIL mult_busy: busy cycles %0d overlap=%b, want 33 and 0", bsy, ovl);
        end
        n_vec++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            n_bad++; $display("FAIL mult_7x-3: hi=%h lo=%h, want ffffffff ffffffeb", hi, lo);
        end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b0 || lo !== 32'hFFFF_FFEB) begin
            n_bad++; $display("FAIL done_pulse: done=%b lo=%h next cycle, want 0 ffffffeb", done, lo);
        end
    endtask

    task automatic test_div_basic();
        int lat, bsy; logic ovl, tmo, dza;
        issue_and_wait(F_DIV, 32'd100, 32'd7, lat, bsy, ovl, tmo, dza);
        n_vec++;
        if (tmo || lat != 33 || lo !== 32'd14 || hi !== 32'd2 || div_by_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL div_100_7: lat=%0d lo=%h hi=%h dbz=%b, want 33 e 2 0", lat, lo, hi, div_by_zero);
        end
        issue_and_wait(F_DIV, 32'hFFFF_FFF9, 32'd2, lat, bsy, ovl, tmo, dza);
        n_vec++;
        if (tmo || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || div_by_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL div_-7_2: lo=%h hi=%h dbz=%b, want fffffffd ffffffff 0", lo, hi, div_by_zero);
        end
    endtask

    task automatic test_div_zero();
        int lat, bsy; logic ovl, tmo, dza;
        issue_and_wait(F_DIV, 32'h1234, 32'h0, lat, bsy, ovl, tmo, dza);
        n_vec++;
        if (tmo || lat != 1 || bsy != 1) begin
            n_bad++; $display("FAIL div0_latency: lat=%0d busy=%0d, want 1 1", lat, bsy);
        end
        n_vec++;
        if (div_by_zero !== 1'b1 || lo !== 32'hFFFF_FFFF || hi !== 32'h1234) begin
            n_bad++;
            $display("FAIL div0_result: dbz=%b lo=%h hi=%h, want 1 ffffffff 00001234", div_by_zero, lo, hi);
        end
        issue_and_wait(F_MULT, 32'd3, 32'd4, lat, bsy, ovl, tmo, dza);
        n_vec++;
        if (dza !== 1'b0 || div_by_zero !== 1'b0 || lo !== 32'd12 || hi !== 32'd0) begin
            n_bad++;
            $display("FAIL div0_clear: dbz after start=%b at done=%b lo=%h hi=%h, want 0 0 c 0",
                     dza, div_by_zero, lo, hi);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, lat, bsy; logic ovl, tmo, dza;
        @(negedge clk);
        start = 1'b1; op = F_MULT; rs_val = 32'd5; rt_val = 32'd6;
        @(posedge clk); #1;
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
        cyc = 0;
        while (!done && cyc < LIMIT) begin
            @(negedge clk);
            if (cyc == 9) begin start = 1'b1; op = F_DIV; rs_val = 32'd9; rt_val = 32'd3; end
            else start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        n_vec++;
        if (cyc != 33 || lo !== 32'd30 || hi !== 32'd0) begin
            n_bad++; $display("FAIL busy_ignore: lat=%0d lo=%h hi=%h, want 33 1e 0", cyc, lo, hi);
        end
        issue_and_wait(F_DIV, 32'd9, 32'd3, lat, bsy, ovl, tmo, dza);
        n_vec++;
        if (tmo || lat != 33 || lo !== 32'd3 || hi !== 32'd0) begin
            n_bad++; $display("FAIL back_to_back: lat=%0d lo=%h hi=%h, want 33 3 0", lat, lo, hi);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bsy, seen; logic ovl, tmo, dza;
        @(negedge clk);
        start = 1'b1; op = F_MULT; rs_val = 32'h1111; rt_val = 32'h2222;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
        end
        seen = 0;
        repeat (2) begin @(posedge clk); #1; if (done) seen++; end
        @(negedge clk);
        rst_b = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
        n_vec++;
        if (seen != 0) begin
            n_bad++; $display("FAIL reset_no_done: %0d cycles with done/busy after reset, want 0", seen);
        end
        issue_and_wait(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bsy, ovl, tmo, dza);
        n_vec++;
        if (tmo || lo !== 32'h8000_0000 || hi !== 32'h0 || div_by_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL div_overflow: lo=%h hi=%h dbz=%b, want 80000000 0 0", lo, hi, div_by_zero);
        end
        hold_hi = hi; hold_lo = lo; hold_dz = div_by_zero;
    endtask

    task automatic test_unsigned();
        int lat, bsy, seen; logic ovl, tmo, dza;
`ifdef MULDIV_UNSIGNED_EN
        issue_and_wait(F_MULTU, 32'hFFFF_FFFF, 32'd2, lat, bsy, ovl, tmo, dza);
        n_vec++;
        if (tmo || lat != 33 || hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin
            n_bad++; $display("FAIL multu: lat=%0d hi=%h lo=%h, want 33 1 fffffffe", lat, hi, lo);
        end
        issue_and_wait(F_DIVU, 32'hFFFF_FFFF, 32'd2, lat, bsy, ovl, tmo, dza);
        n_vec++;
        if (tmo || lat != 33 || lo !== 32'h7FFF_FFFF || hi !== 32'd1) begin
            n_bad++; $display("FAIL divu: lat=%0d lo=%h hi=%h, want 33 7fffffff 1", lat, lo, hi);
        end
        hold_hi = hi; hold_lo = lo; hold_dz = div_by_zero;
`else
        lat = 0; bsy = 0; ovl = 1'b0; tmo = 1'b0; dza = 1'b0;
        @(negedge clk);
        start = 1'b1; op = F_MULTU; rs_val = 32'hFFFF_FFFF; rt_val = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        repeat (4) begin if (busy || done) seen++; @(posedge clk); #1; end
        n_vec++;
        if (seen != 0 || hi !== hold_hi || lo !== hold_lo) begin
            n_bad++;
            $display("FAIL multu_ignored: active=%0d hi=%h lo=%h, want 0 %h %h", seen, hi, lo, hold_hi, hold_lo);
        end
`endif
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [5:0] fl[5];
        logic [5:0] f;
        logic [31:0] a, b, eh, el;
        logic v, ez, ovl, tmo, dza;
        int lat, bsy, seen, want_lat;
        fl[0] = F_MULT; fl[1] = F_DIV; fl[2] = F_MULTU; fl[3] = F_DIVU; fl[4] = F_ADD;
        for (int i = 0; i < 40; i++) begin
            f = fl[$urandom_range(0, 4)];
            a = pick();
            b = pick();
            if ((f == F_DIV || f == F_DIVU) && $urandom_range(0, 5) == 0) b = 32'h0;
            model(f, a, b, v, eh, el, ez);
            if (v) begin
                issue_and_wait(f, a, b, lat, bsy, ovl, tmo, dza);
                want_lat = ez ? 1 : 33;
                n_vec++;
                if (tmo || lat != want_lat || bsy != want_lat || ovl) begin
                    n_bad++;
                    $display("FAIL rnd_timing[%0d] op=%b: lat=%0d busy=%0d ovl=%b, want %0d %0d 0",
                             i, f, lat, bsy, ovl, want_lat, want_lat);
                end
                n_vec++;
                if (hi !== eh || lo !== el || div_by_zero !== ez) begin
                    n_bad++;
                    $display("FAIL rnd_result[%0d] op=%b a=%h b=%h: hi=%h lo=%h dbz=%b, want %h %h %b",
                             i, f, a, b, hi, lo, div_by_zero, eh, el, ez);
                end
                hold_hi = eh; hold_lo = el; hold_dz = ez;
            end else begin
                @(negedge clk);
                start = 1'b1; op = f; rs_val = a; rt_val = b;
                @(posedge clk); #1;
                start = 1'b0;
                seen = 0;
                repeat (3) begin if (busy || done) seen++; @(posedge clk); #1; end
                n_vec++;
                if (seen != 0 || hi !== hold_hi || lo !== hold_lo || div_by_zero !== hold_dz) begin
                    n_bad++;
                    $display("FAIL rnd_invalid[%0d] op=%b: active=%0d hi=%h lo=%h dbz=%b, want 0 %h %h %b",
                             i, f, seen, hi, lo, div_by_zero, hold_hi, hold_lo, hold_dz);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_div_basic();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_op();
        test_unsigned();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
